crc_engine_par: RTL and testbench

Parametrised, beat-parallel successor to the serial CRC block. It consumes DATA_W bits per accepted beat under a valid/ready handshake with frame delimiters. Runtime configuration covers polynomial, CRC length, init value, input/output reflection and final XOR. It emits one registered result per frame, plus a compare flag against an expected value. It sits between the byte-stream framer and the link-layer check logic.

---
 rtl/crc_engine_par.sv | 233 +++++++++++++++++++++++
 tb/tb_crc_engine_par.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine_par.sv
// crc_engine_par: beat-parallel CRC engine with a valid/ready frame interface.
// Each accepted beat advances the CRC by up to DATA_W bits in one cycle. The
// polynomial, active length L, init value, reflection and final XOR are all
// runtime configuration, latched on the start-of-frame beat. One registered
// result is produced per frame, together with a compare flag against exp_crc.
module crc_engine_par #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(CRC_W):0]  cfg_len,
    input  logic [CRC_W-1:0]        cfg_poly,
    input  logic [CRC_W-1:0]        cfg_init,
    input  logic [CRC_W-1:0]        cfg_xorout,
    input  logic                    cfg_refin,
    input  logic                    cfg_refout,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_sof,
    input  logic                    in_last,
    input  logic [$clog2(DATA_W):0] in_last_bits,
    input  logic [CRC_W-1:0]        exp_crc,
    output logic                    crc_valid,
    output logic [CRC_W-1:0]        crc_out,
    output logic                    crc_match,
    output logic                    err_nosof
);

    localparam int LEN_W = $clog2(CRC_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Out-of-range lengths (0 or above CRC_W) fall back to the full width so
    // the mask and top-bit selection always stay inside the register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] l;
        l = len;
        if (len == '0 || int'(len) > CRC_W)
            l = LEN_W'(CRC_W);
        return l;
    endfunction

    // (1 << L) - 1, computed one bit wider so L == CRC_W wraps to all ones.
    function automatic logic [CRC_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [CRC_W:0] one_hot;
        one_hot = (CRC_W+1)'(1) << len;
        return one_hot[CRC_W-1:0] - CRC_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = {<<{x}};
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] x);
        logic [CRC_W-1:0] r;
        r = {<<{x}};
        return r;
    endfunction

    // Unrolled bit-serial update. The beat is pre-reversed for LSB-first order
    // so bits are always consumed from the MSB end; only the first nbits are
    // applied, which selects the top bits (refin=0) or bottom bits (refin=1).
    function automatic logic [CRC_W-1:0] crc_advance(
        input logic [CRC_W-1:0]  crc,
        input logic [DATA_W-1:0] data,
        input int                nbits,
        input logic              refin,
        input logic [CRC_W-1:0]  poly,
        input logic [CRC_W-1:0]  mask
    );
        logic [CRC_W-1:0]  c;
        logic [CRC_W-1:0]  top;
        logic [DATA_W-1:0] sh;
        logic              fb;
        c   = crc;
        top = mask ^ (mask >> 1);
        sh  = refin ? rev_data(data) : data;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < nbits) begin
                fb = (|(c & top)) ^ sh[DATA_W-1];
                c  = (c << 1) & mask;
                if (fb)
                    c = c ^ poly;
                sh = sh << 1;
            end
        end
        return c;
    endfunction

    // Output reflection works on the L-bit value: reversing the full register
    // parks those bits at the top, so shift them back down by CRC_W - L.
    function automatic logic [CRC_W-1:0] crc_finish(
        input logic [CRC_W-1:0] crc,
        input logic [LEN_W-1:0] len,
        input logic             refout,
        input logic [CRC_W-1:0] xorout,
        input logic [CRC_W-1:0] mask
    );
        logic [CRC_W-1:0] r;
        r = refout ? (rev_crc(crc) >> (CRC_W - int'(len))) : crc;
        return (r ^ xorout) & mask;
    endfunction

    state_t           state;
    logic             ready_r;

    logic [LEN_W-1:0] len_p0;
    logic [CRC_W-1:0] mask_p0;
    logic [CRC_W-1:0] poly_p0;
    logic [CRC_W-1:0] xorout_p0;
    logic             refin_p0;
    logic             refout_p0;
    logic [CRC_W-1:0] crc_p0;

    logic             vld_p1;
    logic             err_p1;
    logic [CRC_W-1:0] res_p1;
    logic             match_p1;

    logic             accept;
    logic             start;
    logic             proc_beat;
    logic             frame_end;

    logic [LEN_W-1:0] len_in;
    logic [CRC_W-1:0] mask_in;
    logic [LEN_W-1:0] len_e;
    logic [CRC_W-1:0] mask_e;
    logic [CRC_W-1:0] poly_e;
    logic [CRC_W-1:0] xorout_e;
    logic             refin_e;
    logic             refout_e;
    logic [CRC_W-1:0] crc_base;
    logic [CRC_W-1:0] crc_next;
    logic [CRC_W-1:0] res_next;
    logic             match_next;
    int               nbits;

    // in_ready is only low in DONE, so any accepted sof either opens a frame
    // from IDLE or aborts and restarts the one in progress.
    assign accept    = in_valid && ready_r;
    assign start     = accept && in_sof;
    assign proc_beat = accept && (in_sof || state == S_ACTIVE);
    assign frame_end = proc_beat && in_last;

    // Per-beat CRC datapath; a sof beat uses the live cfg_* it is latching.
    always_comb begin
        len_in     = clamp_len(cfg_len);
        mask_in    = len_mask(len_in);
        len_e      = start ? len_in                : len_p0;
        mask_e     = start ? mask_in               : mask_p0;
        poly_e     = start ? (cfg_poly & mask_in)  : poly_p0;
        xorout_e   = start ? cfg_xorout            : xorout_p0;
        refin_e    = start ? cfg_refin             : refin_p0;
        refout_e   = start ? cfg_refout            : refout_p0;
        crc_base   = start ? (cfg_init & mask_in)  : crc_p0;
        nbits      = (in_last && int'(in_last_bits) != 0 && int'(in_last_bits) <= DATA_W)
                     ? int'(in_last_bits) : DATA_W;
        crc_next   = crc_advance(crc_base, in_data, nbits, refin_e, poly_e, mask_e);
        res_next   = crc_finish(crc_next, len_e, refout_e, xorout_e, mask_e);
        match_next = ((res_next ^ exp_crc) & mask_e) == '0;
    end

    // Stage p0: latched frame configuration and running CRC (data only, no reset).
    always_ff @(posedge clk) begin
        if (start) begin
            len_p0    <= len_in;
            mask_p0   <= mask_in;
            poly_p0   <= cfg_poly & mask_in;
            xorout_p0 <= cfg_xorout;
            refin_p0  <= cfg_refin;
            refout_p0 <= cfg_refout;
        end
        if (proc_beat)
            crc_p0 <= crc_next;
    end

    // Stage p1: frame FSM, handshake, result strobe and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ready_r  <= 1'b1;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            res_p1   <= '0;
            match_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && !in_sof)
                        err_p1 <= 1'b1;
                    if (start)
                        state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    state <= S_ACTIVE;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
            if (frame_end) begin
                state    <= S_DONE;
                ready_r  <= 1'b0;
                vld_p1   <= 1'b1;
                res_p1   <= res_next;
                match_p1 <= match_next;
            end
        end
    end

    assign in_ready  = ready_r;
    assign crc_valid = vld_p1;
    assign crc_out   = res_p1;
    assign crc_match = match_p1;
    assign err_nosof = err_p1;

endmodule

// File: tb/tb_crc_engine_par.sv
// Bench for crc_engine_par: a table of directed frames on a CRC_W=16/DATA_W=8
// instance, plus hand-written sequences for back-to-back, abort, error and
// reset cases, a CRC-32 run on a 32-bit instance and a 1-bit serial instance.
module tb_crc_engine_par;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc   = 0;
    int first_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 16/8 instance ----------------
    logic [4:0]  a_len;
    logic [15:0] a_poly, a_init, a_xor, a_exp, a_co;
    logic        a_ri, a_ro, a_valid, a_ready, a_sof, a_last, a_cv, a_cm, a_err;
    logic [7:0]  a_data;
    logic [3:0]  a_lb;

    crc_engine_par #(.CRC_W(16), .DATA_W(8)) u8 (
        .clk(clk), .rst(rst),
        .cfg_len(a_len), .cfg_poly(a_poly), .cfg_init(a_init), .cfg_xorout(a_xor),
        .cfg_refin(a_ri), .cfg_refout(a_ro),
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_sof(a_sof), .in_last(a_last), .in_last_bits(a_lb), .exp_crc(a_exp),
        .crc_valid(a_cv), .crc_out(a_co), .crc_match(a_cm), .err_nosof(a_err)
    );

    // ---------------- 32/32 instance ----------------
    logic [5:0]  b_len, b_lb;
    logic [31:0] b_poly, b_init, b_xor, b_exp, b_co, b_data;
    logic        b_ri, b_ro, b_valid, b_ready, b_sof, b_last, b_cv, b_cm, b_err;

    crc_engine_par #(.CRC_W(32), .DATA_W(32)) u32 (
        .clk(clk), .rst(rst),
        .cfg_len(b_len), .cfg_poly(b_poly), .cfg_init(b_init), .cfg_xorout(b_xor),
        .cfg_refin(b_ri), .cfg_refout(b_ro),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_sof(b_sof), .in_last(b_last), .in_last_bits(b_lb), .exp_crc(b_exp),
        .crc_valid(b_cv), .crc_out(b_co), .crc_match(b_cm), .err_nosof(b_err)
    );

    // ---------------- 16/1 serial instance ----------------
    logic [4:0]  c_len;
    logic [15:0] c_poly, c_init, c_xor, c_exp, c_co;
    logic        c_ri, c_ro, c_valid, c_ready, c_sof, c_last, c_cv, c_cm, c_err;
    logic [0:0]  c_data, c_lb;

    crc_engine_par #(.CRC_W(16), .DATA_W(1)) u1 (
        .clk(clk), .rst(rst),
        .cfg_len(c_len), .cfg_poly(c_poly), .cfg_init(c_init), .cfg_xorout(c_xor),
        .cfg_refin(c_ri), .cfg_refout(c_ro),
        .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .in_sof(c_sof), .in_last(c_last), .in_last_bits(c_lb), .exp_crc(c_exp),
        .crc_valid(c_cv), .crc_out(c_co), .crc_match(c_cm), .err_nosof(c_err)
    );

    int a_nval = 0;
    int a_low  = 0;
    int b_nval = 0;
    always @(negedge clk) begin
        if (a_cv)     a_nval++;
        if (!a_ready) a_low++;
        if (b_cv)     b_nval++;
    end

    typedef struct {
        logic [4:0]  len;
        logic [15:0] poly;
        logic [15:0] init;
        logic [15:0] xorout;
        logic        ri;
        logic        ro;
        int          n;
        logic [71:0] bytes;
        logic [3:0]  lb;
        logic [15:0] exp;
        logic [15:0] want;
        logic        wm;
    } vec_t;

    vec_t vt[9];
    localparam logic [71:0] S9 = 72'h31_32_33_34_35_36_37_38_39;

    function automatic vec_t mk(input logic [4:0] len, input logic [15:0] poly,
                                input logic [15:0] init, input logic [15:0] xorout,
                                input logic ri, input logic ro, input int n,
                                input logic [71:0] bytes, input logic [3:0] lb,
                                input logic [15:0] exp, input logic [15:0] want,
                                input logic wm);
        vec_t v;
        v.len = len; v.poly = poly; v.init = init; v.xorout = xorout;
        v.ri = ri; v.ro = ro; v.n = n; v.bytes = bytes; v.lb = lb;
        v.exp = exp; v.want = want; v.wm = wm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic a_cfg(input vec_t v);
        a_len = v.len; a_poly = v.poly; a_init = v.init; a_xor = v.xorout;
        a_ri = v.ri; a_ro = v.ro; a_exp = v.exp;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic a_beat(input logic [7:0] d, input logic sof, input logic last,
                          input logic [3:0] lb);
        logic ok;
        ok = 1'b0;
        a_data = d; a_sof = sof; a_last = last; a_lb = lb; a_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = a_ready;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL a_beat ready timeout: got ready=0 want 1");
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        a_valid = 1'b0; a_sof = 1'b0; a_last = 1'b0;
    endtask

    task automatic a_frame(input vec_t v, input bit gaps);
        logic [71:0] sh;
        int g;
        a_cfg(v);
        sh = v.bytes;
        for (int k = 0; k < v.n; k++) begin
            a_beat(sh[71:64], k == 0, k == v.n - 1, (k == v.n - 1) ? v.lb : 4'd0);
            if (k == 0) first_cyc = acc_cyc;
            sh = sh << 8;
            if (gaps && k != v.n - 1) begin
                g = int'($urandom_range(0, 2));
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic a_result(input int id, input logic [15:0] want, input logic wm);
        @(negedge clk);
        check($sformatf("v%0d crc_valid", id), a_cv, 1);
        check($sformatf("v%0d crc_out", id), a_co, want);
        check($sformatf("v%0d crc_match", id), a_cm, wm);
        check($sformatf("v%0d in_ready_low", id), a_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic b_beat(input logic [31:0] d, input logic sof, input logic last,
                          input logic [5:0] lb);
        logic ok;
        ok = 1'b0;
        b_data = d; b_sof = sof; b_last = last; b_lb = lb; b_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = b_ready;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL b_beat ready timeout: got ready=0 want 1");
        end
        @(posedge clk); #1;
        b_valid = 1'b0; b_sof = 1'b0; b_last = 1'b0;
    endtask

    initial begin
        int n0, l0, last1;
        logic [31:0] word;
        logic ok;

        vt[0] = mk(5'd8,  16'h0007, 16'h0000, 16'h0000, 0, 0, 9, S9, 4'd8, 16'h00F4, 16'h00F4, 1);
        vt[1] = mk(5'd16, 16'h8005, 16'h0000, 16'h0000, 1, 1, 9, S9, 4'd8, 16'hBB3D, 16'hBB3D, 1);
        vt[2] = mk(5'd16, 16'h8005, 16'h0000, 16'h0000, 1, 1, 9, S9, 4'd8, 16'hBB3C, 16'hBB3D, 0);
        vt[3] = mk(5'd16, 16'h1021, 16'hFFFF, 16'h0000, 0, 0, 9, S9, 4'd8, 16'h29B1, 16'h29B1, 1);
        vt[4] = mk(5'd8,  16'h0007, 16'h0000, 16'h0000, 0, 0, 1, {8'hA0, 64'h0}, 4'd4, 16'hAB36, 16'h0036, 1);
        vt[5] = mk(5'd8,  16'h0007, 16'h0000, 16'h0000, 0, 0, 1, {8'h31, 64'h0}, 4'd0, 16'h0097, 16'h0097, 1);
        vt[6] = mk(5'd8,  16'h0007, 16'h0000, 16'h00FF, 0, 1, 1, {8'h31, 64'h0}, 4'd8, 16'h0017, 16'h0016, 0);
        vt[7] = mk(5'd8,  16'h0007, 16'h0000, 16'h0000, 0, 0, 4, {32'h12345678, 40'h0}, 4'd8, 16'h001C, 16'h001C, 1);
        vt[8] = mk(5'd8,  16'h0007, 16'h0000, 16'h0000, 1, 0, 1, {8'h05, 64'h0}, 4'd4, 16'h0036, 16'h0036, 1);

        a_len = '0; a_poly = '0; a_init = '0; a_xor = '0; a_exp = '0;
        a_ri = 0; a_ro = 0; a_valid = 0; a_data = '0; a_sof = 0; a_last = 0; a_lb = '0;
        b_len = '0; b_poly = '0; b_init = '0; b_xor = '0; b_exp = '0;
        b_ri = 0; b_ro = 0; b_valid = 0; b_data = '0; b_sof = 0; b_last = 0; b_lb = '0;
        c_len = '0; c_poly = '0; c_init = '0; c_xor = '0; c_exp = '0;
        c_ri = 0; c_ro = 0; c_valid = 0; c_data = '0; c_sof = 0; c_last = 0; c_lb = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst a_ready", a_ready, 1);
        check("rst a_valid", a_cv, 0);
        check("rst a_crc_out", a_co, 0);
        check("rst a_match", a_cm, 0);
        check("rst a_err", a_err, 0);
        check("rst b_ready", b_ready, 1);
        check("rst c_crc_out", c_co, 0);
        @(posedge clk); #1;

        // Table-driven frames; vector 3 uses random valid gaps
        for (int i = 0; i < 9; i++) begin
            a_frame(vt[i], i == 3);
            a_result(i, vt[i].want, vt[i].wm);
        end

        // Back-to-back frames: ready low exactly one cycle, next sof two edges later
        n0 = a_nval; l0 = a_low;
        a_frame(vt[3], 1'b1);
        last1 = acc_cyc;
        a_result(30, 16'h29B1, 1);
        a_frame(vt[3], 1'b0);
        check("b2b sof edge distance", first_cyc - last1, 2);
        a_result(31, 16'h29B1, 1);
        check("b2b ready_low cycles", a_low - l0, 2);
        check("b2b strobes", a_nval - n0, 2);
        @(negedge clk);
        check("hold crc_out", a_co, 16'h29B1);
        check("hold crc_match", a_cm, 1);
        check("strobe one cycle", a_cv, 0);
        @(posedge clk); #1;

        // Beats without sof in IDLE
        n0 = a_nval;
        a_cfg(vt[0]);
        a_beat(8'h55, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        check("nosof pulse", a_err, 1);
        check("nosof no valid", a_cv, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nosof pulse end", a_err, 0);
        @(posedge clk); #1;
        a_beat(8'h66, 1'b0, 1'b1, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("nosof no strobe", a_nval - n0, 0);
        a_frame(vt[5], 1'b0);
        a_result(40, 16'h0097, 1);

        // sof mid-frame restarts; later cfg changes must not matter
        n0 = a_nval;
        a_cfg(vt[1]);
        a_beat(8'h31, 1'b1, 1'b0, 4'd0);
        a_beat(8'h32, 1'b0, 1'b0, 4'd0);
        a_cfg(vt[0]);
        a_beat(8'h31, 1'b1, 1'b0, 4'd0);
        a_poly = 16'h1021; a_len = 5'd16; a_ri = 1; a_ro = 1; a_xor = 16'hFFFF; a_init = 16'h1234;
        for (int k = 2; k <= 8; k++) a_beat(8'h30 + 8'(k), 1'b0, 1'b0, 4'd0);
        a_beat(8'h39, 1'b0, 1'b1, 4'd8);
        a_result(50, 16'h00F4, 1);
        check("abort single strobe", a_nval - n0, 1);

        // Reset mid-frame
        a_cfg(vt[0]);
        a_beat(8'h31, 1'b1, 1'b0, 4'd0);
        a_beat(8'h32, 1'b0, 1'b0, 4'd0);
        n0 = a_nval;
        rst = 1'b1;
        #1;
        check("midrst crc_out", a_co, 0);
        check("midrst valid", a_cv, 0);
        check("midrst ready", a_ready, 1);
        check("midrst match", a_cm, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst no strobe", a_nval - n0, 0);
        check("midrst crc_out hold", a_co, 0);
        a_frame(vt[7], 1'b0);
        a_result(60, 16'h001C, 1);

        // CRC-32 on the 32-bit instance with a partial last beat
        b_len = 6'd32; b_poly = 32'h04C11DB7; b_init = 32'hFFFFFFFF; b_xor = 32'hFFFFFFFF;
        b_ri = 1; b_ro = 1; b_exp = 32'hCBF43926;
        n0 = b_nval;
        b_beat(32'h34333231, 1'b1, 1'b0, 6'd0);
        b_beat(32'h38373635, 1'b0, 1'b0, 6'd0);
        b_beat(32'h00000039, 1'b0, 1'b1, 6'd8);
        @(negedge clk);
        check("crc32 valid", b_cv, 1);
        check("crc32 crc_out", b_co, 32'hCBF43926);
        check("crc32 match", b_cm, 1);
        check("crc32 ready_low", b_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("crc32 hold", b_co, 32'hCBF43926);
        check("crc32 strobes", b_nval - n0, 1);
        @(posedge clk); #1;

        // 1-bit serial instance on 0x12345678, MSB first
        c_len = 5'd8; c_poly = 16'h0007; c_init = '0; c_xor = '0; c_ri = 0; c_ro = 0;
        c_exp = 16'h001C;
        word = 32'h12345678;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            c_data = word[31:31]; c_sof = (i == 0); c_last = (i == 31); c_lb = 1'b1;
            c_valid = 1'b1;
            @(negedge clk);
            if (!c_ready) ok = 1'b0;
            @(posedge clk); #1;
            word = word << 1;
        end
        c_valid = 1'b0; c_sof = 1'b0; c_last = 1'b0;
        check("serial ready during frame", ok, 1);
        @(negedge clk);
        check("serial valid", c_cv, 1);
        check("serial crc_out", c_co, 16'h001C);
        check("serial match", c_cm, 1);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
